// File: rtl/wide_add_seq.sv
// Multi-precision adder: one shared 16-bit CLA slice per clock, LSB slice first (optional subtract via WIDE_ADD_SEQ_SUB_EN).
// Latency: result valid after WORDS RUN edges following the input handshake; one op every WORDS+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds sum/cout frozen until out_ready is seen at an edge.

// 16-bit two-level carry-lookahead adder: 4-bit groups, group lookahead across 4 groups.
module Adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;      // carry into each bit
    logic [3:0]  gg;     // group generate
    logic [3:0]  gp;     // group propagate
    logic [4:0]  gc;     // carry into each group (gc[4] is the carry out)

    // Bit generate/propagate and per-group G/P
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Second-level lookahead: every group carry is a flat AND-OR of cin and group G/P
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

    // In-group carries from the group carry-in, then the sum bits
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        s    = p ^ c;
        cout = gc[4];
    end

endmodule

// Sequencer around a single Adder16. WORDS legal range is 1..16.
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            cy_q,    cy_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic            sub_q,   sub_d;
`endif

    logic [15:0]     add_a;
    logic [15:0]     add_b;
    logic [15:0]     add_s;
    logic            add_cout;
    logic            last_slice;

    assign last_slice = (idx_q == IDX_LAST);

    Adder16 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (cy_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // Slice mux: only registered operands feed the adder, so the carry chain never spans slices
    always_comb begin
        add_a = a_q[{idx_q, 4'd0} +: 16];
        add_b = b_q[{idx_q, 4'd0} +: 16];
`ifdef WIDE_ADD_SEQ_SUB_EN
        // Subtract as A + ~B + 1; the +1 comes from cy being preset at capture
        if (sub_q) begin
            add_b = ~add_b;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, run WORDS slices, wait for the consumer in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)    state_d = ST_RUN;
            ST_RUN:  if (last_slice)  state_d = ST_DONE;
            ST_DONE: if (out_ready)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from registered state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Datapath next values: operand capture, per-slice sum write and carry update
    always_comb begin
        idx_d  = idx_q;
        cy_d   = cy_q;
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        cout_d = cout_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub_d  = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    idx_d = '0;
                    cy_d  = cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
                    sub_d = sub;
                    if (sub) begin
                        cy_d = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                sum_d[{idx_q, 4'd0} +: 16] = add_s;
                cy_d                       = add_cout;
                if (last_slice) begin
                    // Wrap idx so a non-power-of-two WORDS never leaves it out of range
                    idx_d  = '0;
                    cout_d = add_cout;
                end else begin
                    idx_d  = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cy_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            idx_q  <= idx_d;
            cy_q   <= cy_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q  <= sub_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq (WORDS=4): directed and random operations against a full-width arithmetic model.
// Expected results are queued at each accepted handshake; a negedge monitor checks latency and result on consumption.
// Covers reset values, carry propagation, backpressure hold, mid-run reset and back-to-back throughput.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          cin_i;
    logic          sub_i;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [W:0]  exp_q[$];   // {cout, sum} per accepted op
    int unsigned acc_q[$];   // cycle number of the accepting edge
    logic        ov_prev = 1'b0;

    task automatic chk_vec(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, no slicing
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, queue the expected result
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb);
        int n;
        a_i = x; b_i = y; cin_i = ci; sub_i = sb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        tick();
        exp_q.push_back(model(x, y, ci, sb));
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk_int("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: latency on each out_valid rise, result check on each consumed output
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_valid: out_valid=1 expected 0 (no op pending)");
                end else begin
                    chk_int("latency", int'(cyc - acc_q[0]), WORDS);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_result: got %h expected none", {cout, sum});
                end else begin
                    chk_vec("result", {cout, sum}, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   hold_exp;
        logic [W-1:0] ra, rb;
        int unsigned  prev_acc;
        int           n;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_vec("rst_sum_cout", {cout, sum}, '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Carry out of slice 0 into slice 1
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        chk_bit("busy_in_run", busy, 1'b1);
        drain();
        // cin ripples through every slice via cy
        do_op({W{1'b1}}, '0, 1'b1, 1'b0);
        drain();

        // Backpressure: hold DONE for 5 cycles while in_valid/a wiggle
        out_ready = 1'b0;
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        hold_exp = model(ra, rb, 1'b1, 1'b0);
        do_op(ra, rb, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk_bit("bp_reach_done", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a_i = {$urandom, $urandom};
            tick();
            chk_bit("bp_out_valid", out_valid, 1'b1);
            chk_bit("bp_in_ready", in_ready, 1'b0);
            chk_vec("bp_held", {cout, sum}, hold_exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_bit("bp_consumed", out_valid, 1'b0);
        chk_bit("bp_idle", in_ready, 1'b1);
        drain();

`ifdef WIDE_ADD_SEQ_SUB_EN
        do_op(64'd5, 64'd7, 1'b0, 1'b1);
        drain();
        do_op(64'd7, 64'd5, 1'b1, 1'b1);
        drain();
`endif

        // Reset while idx=2 in RUN
        do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_vec("midrst_sum", {cout, sum}, '0);
        #2 rst_n = 1'b1;
        tick();
        do_op(64'd3, 64'd4, 1'b0, 1'b0);
        drain();

        // Back-to-back random ops with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = 0;
        for (int k = 0; k < 20; k++) begin
            ra = {$urandom, $urandom};
            rb = (k % 5 == 0) ? ~ra : {$urandom, $urandom};
            a_i = ra; b_i = rb; cin_i = 1'($urandom_range(0, 1)); sub_i = 1'b0;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL b2b_accept_timeout: in_ready=%b expected 1", in_ready);
                break;
            end
            tick();
            exp_q.push_back(model(ra, rb, cin_i, 1'b0));
            acc_q.push_back(cyc);
            if (k > 0) chk_int("b2b_spacing", int'(cyc - prev_acc), WORDS + 2);
            prev_acc = cyc;
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-precision add sequencer that computes a (16×WORDS)-bit sum by time-multiplexing a single instance of the team's 16-bit carry-lookahead adder (`Adder16`), one 16-bit slice per clock, LSB slice first. A registered carry links successive slices. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side, and replaces a full-width combinational adder wherever area matters more than latency.

## Interface
- `WORDS`, default 4: number of 16-bit slices; operand width W = 16×WORDS; legal range 1..16.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand request.
- `in_ready`, output, 1: block can accept operands; high only in IDLE.
- `a`, input, W: operand A; sampled only at the input handshake.
- `b`, input, W: operand B; sampled only at the input handshake.
- `cin`, input, 1: carry-in to slice 0; sampled at the input handshake.
- `sub`, input, 1: subtract A−B; present only when `WIDE_ADD_SEQ_SUB_EN` is defined.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer accepts the result.
- `sum`, output, W: result register.
- `cout`, output, 1: carry out of the top slice.
- `busy`, output, 1: state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE. Supporting registers: slice index `idx` (width clog2(WORDS), min 1), carry register `cy`, operand registers `a_q`/`b_q`, and the `sum` register.
- IDLE: `in_ready`=1. When `in_valid`&&`in_ready` at an edge: latch `a`/`b` into `a_q`/`b_q`, set `cy`=`cin`, set `idx`=0, go to RUN.
- RUN: the adder receives `a_q[16·idx+:16]`, `b_q[16·idx+:16]`, and `cy`. Each edge writes the adder's `s` into `sum[16·idx+:16]`, sets `cy` to the adder's `cout`, and increments `idx`. At the edge where `idx`==WORDS−1, the block also loads `cout` from the adder and goes to DONE.
- DONE: `out_valid`=1. `sum` and `cout` are held stable. When `out_ready`=1 at an edge, the block goes to IDLE.
- `in_valid` is ignored outside IDLE. Operands change nothing after capture.
- Arithmetic is modulo 2^W. `cout` is the true carry out of bit W−1. The sum is exact for any `cin`.
- `sum` slices update during RUN, so partial results are visible. The value is defined only while `out_valid`=1.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `cy`=0, `idx`=0.
- Latency: input handshake at edge N, then `out_valid` rises after edge N+WORDS.
- Throughput: if `in_valid` and `out_ready` are held high, one operation every WORDS+2 cycles: accept, WORDS RUN edges, DONE handshake edge.
- `in_ready`, `out_valid`, and `busy` are decoded from registered state. There are no combinational paths from inputs to outputs.
- Backpressure: DONE persists indefinitely with outputs frozen. It is legal for `out_ready` to be high before `out_valid`.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately. The in-flight result is discarded and no `out_valid` pulse occurs. The next accepted operation is unaffected.
- Critical path: one `Adder16` plus the slice mux. The carry feedback goes through `cy` only; there is no multi-slice combinational ripple.

## Configuration
- `WIDE_ADD_SEQ_SUB_EN` defined:
  - The `sub` port exists and is latched at the handshake.
  - With `sub`=1, every B slice is inverted into the adder and `cy` is initialised to 1; `cin` is ignored. `sum`=A−B mod 2^W, and `cout`=1 means no borrow (A≥B unsigned).
  - With `sub`=0, behaviour is identical to the undefined case.
- Undefined: the `sub` port is absent and the block is add-only.

## Test plan
1. WORDS=4: a=0x0000_0000_0000_FFFF, b=1, cin=0. Expect sum=0x0000_0000_0001_0000, cout=0, and `out_valid` exactly 4 cycles after the handshake.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1. Expect sum=0, cout=1, confirming the carry propagates through all slices via `cy`.
3. Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid`/`a`. Expect `sum`/`cout`/`out_valid` unchanged, `in_ready`=0, and the result consumed on the first edge with `out_ready`=1.
4. Sub (macro on): a=5, b=7, sub=1 gives sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. a=7, b=5, sub=1 gives sum=2, cout=1.
5. Pull `rst_n` low while `idx`=2 in RUN. Expect immediate `out_valid`=0, `sum`=0, `in_ready`=1. A following op (a=3, b=4) gives sum=7.
6. Back-to-back with `in_valid`=`out_ready`=1 and random operands. Expect accepts every 6 cycles (WORDS=4), every result matching a scoreboard a+b+cin, and no lost or duplicate `out_valid` pulse.
